// File: rtl/action_arbiter.sv
// Round-robin arbiter for pet-care requests: latches rising edges, offers one
// action at a time over valid/ready, then holds off for COOLDOWN cycles.
//
// state | meaning
// IDLE  | waiting for en and a pending request
// OFFER | act_valid high, code/onehot frozen until act_ready
// HOLD  | cooldown countdown after an accepted action
module action_arbiter #(
    parameter int unsigned COOLDOWN = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_salud,
    input  logic       req_hambre,
    input  logic       req_diversion,
    input  logic       req_energia,
    input  logic       en,
    input  logic       act_ready,
    output logic       act_valid,
    output logic [1:0] act_code,
    output logic [3:0] act_onehot,
    output logic [3:0] pending,
    output logic       busy,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

    localparam logic [25:0] CNT_LOAD = 26'(COOLDOWN - 1);

    state_t      state;
    logic [3:0]  req;
    logic [3:0]  prev;
    logic [3:0]  edge_det;
    logic [3:0]  clr;
    logic [3:0]  drops;
    logic [25:0] cnt;
    logic [1:0]  ptr;
    logic [2:0]  n_drops;
    logic [8:0]  drop_sum;
    logic [1:0]  win_code;
    logic [1:0]  idx;

    assign req      = {req_energia, req_diversion, req_hambre, req_salud};
    assign edge_det = req & ~prev;
    // act_onehot is zero outside OFFER, so it doubles as the clear mask
    assign clr      = (act_valid && act_ready) ? act_onehot : 4'b0000;
    assign drops    = edge_det & pending & ~clr;

    always_comb begin
        n_drops = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n_drops = n_drops + {2'b00, drops[i]};
        end
        drop_sum = {1'b0, drop_count} + {6'b000000, n_drops};
    end

    // Search downward so the last hit is the first set bit at or above ptr
    always_comb begin
        win_code = ptr;
        idx      = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (pending[idx]) begin
                win_code = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= 4'b1111;
            pending    <= 4'b0000;
            drop_count <= 8'd0;
            act_valid  <= 1'b0;
            act_code   <= 2'd0;
            act_onehot <= 4'b0000;
            busy       <= 1'b0;
            cnt        <= 26'd0;
            ptr        <= 2'd0;
        end else begin
            prev       <= req;
            pending    <= (pending & ~clr) | edge_det;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (en && (pending != 4'b0000)) begin
                        state      <= OFFER;
                        act_valid  <= 1'b1;
                        act_code   <= win_code;
                        act_onehot <= 4'b0001 << win_code;
                        busy       <= 1'b1;
                    end
                end
                OFFER: begin
                    if (act_ready) begin
                        state      <= HOLD;
                        act_valid  <= 1'b0;
                        act_onehot <= 4'b0000;
                        ptr        <= act_code + 2'd1;
                        cnt        <= CNT_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt == 26'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 26'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_arbiter.sv
// Scoreboard bench for action_arbiter: stimulus queues expected action codes,
// a negedge monitor pops and compares them on every handshake.
`timescale 1ns/1ps
module tb_action_arbiter;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       en;
    logic       act_ready;
    logic       act_valid;
    logic [1:0] act_code;
    logic [3:0] act_onehot;
    logic [3:0] pending;
    logic       busy;
    logic [7:0] drop_count;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [1:0] exp_q[$];
    int         hs_log[$];
    logic [1:0] e;

    action_arbiter #(.COOLDOWN(CD)) dut (
        .clk(clk), .rst(rst),
        .req_salud(req[0]), .req_hambre(req[1]),
        .req_diversion(req[2]), .req_energia(req[3]),
        .en(en), .act_ready(act_ready),
        .act_valid(act_valid), .act_code(act_code), .act_onehot(act_onehot),
        .pending(pending), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail(string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout or unexpected event", name);
    endtask

    // Handshake monitor / scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1 && act_valid === 1'b1 && act_ready === 1'b1) begin
            hs_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                fail("unexpected_action");
            end else begin
                e = exp_q.pop_front();
                check("act_code", {30'd0, act_code}, {30'd0, e});
                check("act_onehot", {28'd0, act_onehot}, {28'd0, 4'b0001 << e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(logic [3:0] m);
        tick();
        req = m;
        tick();
        req = 4'b0000;
    endtask

    task automatic check_reset_vals(string name);
        check(name, {16'd0, act_valid, act_code, act_onehot, pending, busy, drop_count}, 32'd0);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (act_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail(name);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && act_valid === 1'b0 && pending === 4'b0000)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int bad;
        int cyc_at;
        rst = 1'b0;
        req = 4'b1000;
        en = 1'b1;
        act_ready = 1'b1;

        // Reset state, energia held high across release
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        tick();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("held_req_no_edge", {28'd0, pending}, 32'd0);
        check("held_req_no_valid", {31'd0, act_valid}, 32'd0);
        req = 4'b0000;

        // Single request on hambre
        exp_q.push_back(2'd1);
        pulse(4'b0010);
        @(negedge clk);
        check("single_pending", {28'd0, pending}, 32'h2);
        check("single_not_yet_valid", {31'd0, act_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("single_latency2", {31'd0, act_valid}, 32'd1);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
        end
        check("busy_cycles", bc, CD + 1);
        check("single_pending_cleared", {28'd0, pending}, 32'd0);
        wait_idle("single_idle");

        // Simultaneous requests from a fresh ptr
        do_reset();
        hs_log.delete();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        pulse(4'b1111);
        wait_idle("simul_idle");
        check("simul_hs_count", hs_log.size(), 4);
        for (int i = 1; i < hs_log.size(); i++) begin
            check("simul_spacing", hs_log[i] - hs_log[i-1], CD + 2);
        end
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        pulse(4'b1001);
        wait_idle("wrap_idle");

        // Backpressure: offer of source 2 frozen while inputs churn
        act_ready = 1'b0;
        exp_q.push_back(2'd2);
        pulse(4'b0100);
        wait_valid("bp_valid");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            en = i[0];
            req = (i % 3 == 0) ? 4'b1011 : 4'b0000;
            @(negedge clk);
            if ({act_valid, act_code, act_onehot} !== 7'b1_10_0100) bad++;
        end
        check("bp_stable", bad, 0);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        tick();
        req = 4'b0000;
        en = 1'b1;
        act_ready = 1'b1;
        hs_log.delete();
        cyc_at = cyc;
        @(negedge clk);
        #1;
        check("bp_hs_first_ready", hs_log.size(), 1);
        if (hs_log.size() > 0) check("bp_hs_cycle", hs_log[0], cyc_at);
        wait_idle("bp_idle");

        // Drops and gating
        do_reset();
        en = 1'b0;
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0001);
        @(negedge clk);
        check("drop_three_edges", {24'd0, drop_count}, 32'd2);
        check("gated_pending", {28'd0, pending}, 32'h1);
        check("gated_no_valid", {31'd0, act_valid}, 32'd0);
        pulse(4'b1111);
        pulse(4'b1111);
        @(negedge clk);
        check("multi_drop", {24'd0, drop_count}, 32'd7);
        check("multi_pending", {28'd0, pending}, 32'hF);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        tick();
        en = 1'b1;
        tick();
        @(negedge clk);
        check("en_offer_1cycle", {31'd0, act_valid}, 32'd1);
        wait_idle("drop_idle");
        check("drop_after_serve", {24'd0, drop_count}, 32'd7);

        // Saturation
        en = 1'b0;
        for (int i = 0; i < 248; i++) pulse(4'b0001);
        @(negedge clk);
        check("drop_254", {24'd0, drop_count}, 32'd254);
        pulse(4'b0001);
        @(negedge clk);
        check("drop_255", {24'd0, drop_count}, 32'd255);
        for (int i = 0; i < 52; i++) pulse(4'b0001);
        @(negedge clk);
        check("drop_saturated", {24'd0, drop_count}, 32'd255);

        // Reset during OFFER
        do_reset();
        en = 1'b1;
        act_ready = 1'b0;
        pulse(4'b0001);
        wait_valid("rst_offer_valid");
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("reset_in_offer");
        tick();
        tick();
        rst = 1'b1;

        // Reset during HOLD
        act_ready = 1'b1;
        exp_q.push_back(2'd1);
        pulse(4'b0010);
        bc = 0;
        while (!(busy === 1'b1 && act_valid === 1'b0) && bc < 50) begin
            @(negedge clk);
            bc++;
        end
        if (bc >= 50) fail("rst_hold_reach");
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("reset_in_hold");
        tick();
        rst = 1'b1;

        // Normal latency after release
        exp_q.push_back(2'd3);
        pulse(4'b1000);
        @(negedge clk);
        check("post_rst_pending", {28'd0, pending}, 32'h8);
        check("post_rst_not_yet", {31'd0, act_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_latency2", {31'd0, act_valid}, 32'd1);
        wait_idle("post_rst_idle");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/action_arbiter.md
# action_arbiter

Arbitrates pet-care requests from the debounced buttons and the sensor front-ends: salud, hambre, diversion (ultrasonic) and energia (MPU6050 tilt). The result is one action at a time, presented to the pet state machine over a valid/ready handshake. The block sits between the input conditioning (`topBtn`, ultrasonic top, MPU6050 demo) and `tamagotchi_fsm`. It latches rising edges so short pulses are never lost, serves pending sources round-robin, and enforces a fixed cooldown after every accepted action.

## Interface
Parameters:
- `COOLDOWN`, default 50_000_000: number of cycles spent in HOLD after each accepted action. Legal range is 1 to 2^26-1.

Ports:
- `clk`, input, 1: system clock. This is the single clock domain.
- `rst`, input, 1: reset. Asynchronous, active-low.
- `req_salud`, input, 1: level request; its rising edge is source 0.
- `req_hambre`, input, 1: level request; its rising edge is source 1.
- `req_diversion`, input, 1: level request; its rising edge is source 2.
- `req_energia`, input, 1: level request; its rising edge is source 3.
- `en`, input, 1: when high, new offers are permitted. Low means the pet is asleep or in test mode.
- `act_ready`, input, 1: the pet FSM accepts the current action.
- `act_valid`, output, 1: an action is offered.
- `act_code`, output, 2: index of the offered source.
- `act_onehot`, output, 4: one-hot form of `act_code`; all zeros when `act_valid` is 0.
- `pending`, output, 4: latched, unserved requests, indexed by source.
- `busy`, output, 1: high in OFFER or HOLD.
- `drop_count`, output, 8: saturating count of rejected request edges.

## Operation
Edge detection:
- Each `req_*` input is registered into `prev[i]`. A rising edge is `req_i & ~prev[i]`.
- `prev` resets to 4'b1111, so an input held high through reset release produces no edge.

Pending bits:
- An edge sets `pending[i]`.
- If `pending[i]` is already 1 and is not being cleared in the same cycle, the edge is dropped and `drop_count` increments. `drop_count` saturates at 255.
- Several drops in one cycle increment `drop_count` by that number, still saturating.
- `pending[i]` is cleared on a handshake (`act_valid & act_ready`) for source i. If an edge on source i arrives in the handshake cycle, the set wins: `pending[i]` stays 1 and the edge is not counted as a drop.

State machine (IDLE, OFFER, HOLD):
- IDLE: if `en` is high and `pending != 0`, pick the winner and go to OFFER. Otherwise remain in IDLE.
- Winner selection: the first set bit found searching upward from `ptr`, modulo 4. `ptr` resets to 0.
- OFFER: `act_valid`=1. `act_code` and `act_onehot` are registered at IDLE→OFFER and stay stable until the handshake.
  - The offer is never retracted. A drop of `en` or new requests do not change it.
  - On `act_ready`: `ptr` becomes granted+1 modulo 4, load `cnt` with COOLDOWN-1, and go to HOLD.
- HOLD: `act_valid`=0. `cnt` decrements each cycle; at `cnt`==0 go to IDLE. Edges continue to be latched during HOLD.

Reset values (asynchronous, all registers):
- state=IDLE, `act_valid`=0, `act_code`=0, `act_onehot`=0, `pending`=0, `busy`=0, `drop_count`=0, `cnt`=0, `ptr`=0.

## Timing
- A request input rises before edge k. Then `pending[i]`=1 after edge k.
- If the FSM is in IDLE with `en`=1, `act_valid`=1 after edge k+1. Latency from the request rising to `act_valid` is 2 cycles.
- Handshake sampled at edge h:
  - After h: `act_valid`=0, `pending[i]`=0, state=HOLD.
  - HOLD occupies cycles h+1 through h+COOLDOWN.
  - IDLE occupies cycle h+COOLDOWN+1.
  - The next `act_valid` appears after edge h+COOLDOWN+1, i.e. COOLDOWN+2 cycles after the previous handshake edge.
- `act_ready` is ignored when `act_valid`=0.
- `busy` is registered and equals (state != IDLE).
- Asserting reset during OFFER or HOLD aborts immediately: the outputs go to their reset values with no handshake completed. On reset release the FSM starts in IDLE with nothing pending.

## Test plan
- Single request, COOLDOWN=4: pulse `req_hambre` for 1 cycle with `act_ready`=1 -> `act_valid` 2 cycles later with `act_code`=1, `act_onehot`=0010. The pending bit clears on the handshake; `busy` is high for exactly 5 cycles (1 OFFER + 4 HOLD).
- Simultaneous requests: raise all four in the same cycle, `act_ready`=1, COOLDOWN=4 -> `act_code` sequence 0,1,2,3, with handshakes spaced 6 cycles apart. Then request sources 3 and 0 together -> 0 is served first (`ptr` has wrapped to 0), then 3.
- Backpressure: hold `act_ready`=0 for 20 cycles during OFFER while toggling `en` and the other requests -> `act_valid`, `act_code` and `act_onehot` remain constant. The handshake occurs on the first cycle with `act_ready`=1.
- Drops: give `req_salud` three rising edges before it is served -> `drop_count`=2 and exactly one action is issued. Pulse 300 drops -> `drop_count` holds at 255.
- Gating and reset-held inputs: keep `req_energia` high through reset release -> no pending bit is set. With `en`=0, pulse `req_salud` -> `pending`=0001 and no `act_valid`. Raise `en` -> offer `act_code`=0 after 1 cycle.
- Reset mid-operation: assert `rst`=0 asynchronously during OFFER and again during HOLD -> all outputs are at reset values before the next clock edge. After release, a new request is served with the normal 2-cycle latency.
